// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-programmable pattern (1..MAX_LEN bits),
// overlap control, a same-cycle Mealy match, a registered Moore match and a saturating match counter.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1101,
    parameter int                 RST_LEN     = 4,
    parameter logic               RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_seq,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               mealy_Y,
    output logic               moore_Y,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    // The oldest bit of the window is never compared again, so only MAX_LEN-1 bits are kept.
    logic [MAX_LEN-2:0] hist_r;
    logic [LEN_W-1:0]   fill_r;

    logic [MAX_LEN-1:0] hist_n_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               accept_s;
    logic               fill_ok_s;
    logic               bits_ok_s;
    logic               match_s;
    logic [LEN_W-1:0]   fill_inc_s;
    logic [LEN_W-1:0]   fill_n_s;
    logic [LEN_W-1:0]   len_clamp_s;

    assign accept_s = in_valid & ~cfg_load;
    assign hist_n_s = {hist_r, in_seq};

    // Match evaluation on the candidate window and next-state fill computation.
    always_comb begin
        mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len_r));
        end
        fill_ok_s = ((LEN_W + 1)'(fill_r) + (LEN_W + 1)'(1)) >= (LEN_W + 1)'(len_r);
        bits_ok_s = (((hist_n_s ^ pattern_r) & mask_s) == {MAX_LEN{1'b0}});
        match_s   = accept_s & (len_r != {LEN_W{1'b0}}) & fill_ok_s & bits_ok_s;

        if (fill_r >= len_r) begin
            fill_inc_s = len_r;
        end else begin
            fill_inc_s = fill_r + LEN_W'(1);
        end

        if (match_s && !ovl_r) begin
            fill_n_s = {LEN_W{1'b0}};
        end else begin
            fill_n_s = fill_inc_s;
        end

        if (cfg_len > MAX_LEN_L) begin
            len_clamp_s = MAX_LEN_L;
        end else begin
            len_clamp_s = cfg_len;
        end
    end

    assign mealy_Y = match_s;

    // Configuration registers, detector history/fill and the Moore flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_r <= RST_PATTERN;
            len_r     <= LEN_W'(RST_LEN);
            ovl_r     <= RST_OVERLAP;
            hist_r    <= {(MAX_LEN - 1){1'b0}};
            fill_r    <= {LEN_W{1'b0}};
            moore_Y   <= 1'b0;
        end else if (cfg_load) begin
            pattern_r <= cfg_pattern;
            len_r     <= len_clamp_s;
            ovl_r     <= cfg_overlap;
            hist_r    <= {(MAX_LEN - 1){1'b0}};
            fill_r    <= {LEN_W{1'b0}};
            moore_Y   <= 1'b0;
        end else if (accept_s) begin
            hist_r    <= hist_n_s[MAX_LEN-2:0];
            fill_r    <= fill_n_s;
            moore_Y   <= match_s;
        end else begin
            hist_r    <= hist_r;
            fill_r    <= fill_r;
            moore_Y   <= moore_Y;
        end
    end

    // Saturating match counter; a clear in the same cycle as a match wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= {CNT_W{1'b0}};
        end else if (count_clr) begin
            match_count <= {CNT_W{1'b0}};
        end else if (match_s && (match_count != CNT_MAX)) begin
            match_count <= match_count + CNT_W'(1);
        end else begin
            match_count <= match_count;
        end
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector and the successor to the fixed-pattern Moore/Mealy sequence detectors. It provides the following:
- Runtime-programmable pattern of 1..MAX_LEN bits.
- Overlapping or non-overlapping detection.
- An input qualifier.
- Both a Mealy (same-cycle) and a Moore (registered) match output.
- A saturating match counter.

It sits on a serial bit stream between a deserialiser/source and control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of length fields
CNT_W, 8, match counter width
RST_PATTERN, 8'b0000_1101, pattern loaded at reset (low MAX_LEN bits used)
RST_LEN, 4, pattern length loaded at reset
RST_OVERLAP, 1, overlap mode loaded at reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies in_seq; bit consumed only when 1
in_seq  input  1  serial data bit
cfg_load  input  1  single-cycle pulse: capture cfg_* into config registers
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1 = overlapping detection, 0 = detector restarts after each match
count_clr  input  1  synchronous clear of match_count
mealy_Y  output  1  combinational match on the current accepted bit
moore_Y  output  1  registered match flag
match_count  output  CNT_W  saturating number of matches since reset/clear

Behaviour:
- Reset (async, immediate):
  - Outputs: moore_Y=0, match_count=0, mealy_Y=0.
  - Detector state: hist=0, fill=0.
  - Config registers: pattern_r=RST_PATTERN, len_r=RST_LEN, ovl_r=RST_OVERLAP.
- State:
  - hist[MAX_LEN-1:0] holds the most recent accepted bits, newest in bit 0.
  - fill counts accepted bits since the last restart and saturates at len_r.
- Effective length L:
  - L = len_r, except cfg_len > MAX_LEN is clamped to MAX_LEN at load.
  - L=0 disables detection: mealy_Y and moore_Y are held at 0; hist and fill still update.
- Bit acceptance (in_valid=1 and cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], in_seq}.
  - match = (fill >= L-1) && (hist_n[L-1:0] == pattern_r[L-1:0]).
  - mealy_Y = match in the same cycle, with no register.
  - Edge update: hist <= hist_n.
  - Overlap mode, or no match: fill <= min(fill+1, L).
  - Non-overlap mode with match: fill <= 0. hist is still updated but ignored until fill refills.
- in_valid=0: mealy_Y=0. hist, fill and moore_Y hold their values (stalls are transparent).
- moore_Y:
  - Loads match on every accepted bit, so it asserts 1 cycle after mealy_Y.
  - Holds until the next accepted bit or cfg_load.
- match_count: +1 on each edge where match=1; saturates at 2^CNT_W-1 with no wrap.
- count_clr:
  - match_count <= 0.
  - If count_clr and match occur in the same cycle, clear wins and the result is 0.
  - Does not affect detector state.
- cfg_load:
  - Captures pattern, clamped length and overlap.
  - Sets hist=0, fill=0, moore_Y=0. match_count is unchanged.
  - If in_valid=1 in the same cycle, the bit is dropped and mealy_Y is forced to 0.
  - The new config applies from the next accepted bit.
- Latency: mealy 0 cycles from the last pattern bit; moore 1 cycle.
- Reset mid-stream: partial matches are discarded; detection restarts from the reset config.

Test Plan:
- Reset config (1101, L=4, overlap), stream 1,1,0,1,1,0,1 with in_valid=1 → mealy_Y pulses on bits 4 and 7; moore_Y high in the cycles after them; match_count=2.
- cfg_load pattern 1101, L=4, overlap=0, same stream → a single match on bit 4; match_count increments by 1.
- Reset config; stream 1,1,0,1 with in_valid=0 gaps of 3 cycles between bits → match on bit 4 only. moore_Y asserts after bit 4 and stays 1 through the subsequent idle cycles until the next accepted bit.
- CNT_W=2; pattern 11, L=2, overlap; twelve accepted 1s → 11 matches, match_count saturates at 3. count_clr asserted together with a match → match_count=0.
- Load 110 (L=3) after feeding 1,1 under 1101, then feed 0 → the first two bits are discarded, no match. Then feeding 1,1,0 → match on the third bit. cfg_load with in_valid=1 in the same cycle → bit dropped, mealy_Y=0.
- Assert reset mid-pattern after 1,1,0 → outputs 0 immediately. After release, feeding 1 → no match; feeding 1,1,0,1 → match.
